// File: rtl/sram_pkg.sv
// ---------------------------------------------------------------------------
// sram_pkg : shared state encoding and mux-select values for the SRAM arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sram_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    ACK       = 3'd4
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

`default_nettype wire

// File: rtl/arb_prio2.sv
// ---------------------------------------------------------------------------
// arb_prio2 : A-priority winner select with a starvation override for B
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module arb_prio2 (
  input  logic req_a,
  input  logic req_b,
  input  logic starve_hit,
  output logic win_b
);

  assign win_b = req_b & (~req_a | starve_hit);

endmodule

`default_nettype wire

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter : two-port scheduler (display reader A, SPI host B) in front of
//                the SRAM mux/controller; issues start, tracks ready, acks.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sram_arbiter
  import sram_pkg::*;
#(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int B_MAXWAIT = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic          sram_clk,
  input  logic          reset,
  input  logic          req_a,
  input  logic          rw_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  input  logic          req_b,
  input  logic          rw_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_b,
  output logic          ack_a,
  output logic          ack_b,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          select,
  output logic          start,
  input  logic          sram_ready,
  input  logic [DW-1:0] sram_rdata
);

  state_t        state_q;
  logic          sel_q;
  logic          rw_q;
  logic          start_q;
  logic          ack_a_q;
  logic          ack_b_q;
  logic          err_q;
  logic [DW-1:0] rdata_q;
  logic [3:0]    starve_q;
  logic [7:0]    tmo_q;

  logic starve_hit;
  logic tmo_hit;
  logic win_b;
  logic unused_buses;

  // Address/write-data buses go straight from the requesters to the mux.
  assign unused_buses = ^{addr_a, addr_b, wdata_a, wdata_b};

  assign starve_hit = (starve_q == 4'(B_MAXWAIT));
  // tmo counts 0..TIMEOUT-1, so the abort fires after TIMEOUT waiting cycles
  assign tmo_hit    = (tmo_q == 8'(TIMEOUT - 1));

  arb_prio2 u_prio (
    .req_a      (req_a),
    .req_b      (req_b),
    .starve_hit (starve_hit),
    .win_b      (win_b)
  );

  always_ff @(posedge sram_clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sel_q    <= SEL_A;
      rw_q     <= 1'b0;
      start_q  <= 1'b0;
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      starve_q <= '0;
      tmo_q    <= '0;
    end else begin
      start_q <= 1'b0;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      tmo_q   <= '0;
      unique case (state_q)
        IDLE: begin
          if (req_a || req_b) begin
            sel_q   <= win_b ? SEL_B : SEL_A;
            rw_q    <= win_b ? rw_b : rw_a;
            start_q <= 1'b1;
            state_q <= ISSUE;
            if (win_b) begin
              starve_q <= '0;
            end else if (req_b && !starve_hit) begin
              starve_q <= starve_q + 4'd1;
            end
          end
        end
        ISSUE: begin
          state_q <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!sram_ready) begin
            state_q <= WAIT_DONE;
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            ack_a_q <= (sel_q == SEL_A);
            ack_b_q <= (sel_q == SEL_B);
            state_q <= ACK;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        WAIT_DONE: begin
          if (sram_ready) begin
            if (rw_q) begin
              rdata_q <= sram_rdata;
            end
            ack_a_q <= (sel_q == SEL_A);
            ack_b_q <= (sel_q == SEL_B);
            state_q <= ACK;
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            ack_a_q <= (sel_q == SEL_A);
            ack_b_q <= (sel_q == SEL_B);
            state_q <= ACK;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        ACK: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack_a  = ack_a_q;
  assign ack_b  = ack_b_q;
  assign rdata  = rdata_q;
  assign err    = err_q;
  assign select = sel_q;
  assign start  = start_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter : directed + randomized bench with an SRAM controller model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sram_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int MAXW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_a = 1'b0, rw_a = 1'b0, req_b = 1'b0, rw_b = 1'b0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] wdata_a = '0, wdata_b = '0;
  logic          ack_a, ack_b, err, select, start, sram_ready;
  logic [DW-1:0] rdata, sram_rdata;

  always #5 clk = ~clk;

  sram_arbiter #(.AW(AW), .DW(DW), .B_MAXWAIT(MAXW), .TIMEOUT(255)) dut (
    .sram_clk   (clk),
    .reset      (rst),
    .req_a      (req_a),
    .rw_a       (rw_a),
    .addr_a     (addr_a),
    .wdata_a    (wdata_a),
    .req_b      (req_b),
    .rw_b       (rw_b),
    .addr_b     (addr_b),
    .wdata_b    (wdata_b),
    .ack_a      (ack_a),
    .ack_b      (ack_b),
    .rdata      (rdata),
    .err        (err),
    .select     (select),
    .start      (start),
    .sram_ready (sram_ready),
    .sram_rdata (sram_rdata)
  );

  // ---------------- SRAM controller model (256 words, low address byte) -----
  logic [DW-1:0] mem [0:255];
  int            busy_left;
  int            lat_fix = 1;
  logic          stuck = 1'b0;
  logic          op_rw;
  logic [7:0]    op_addr;
  logic [DW-1:0] op_wd;

  function automatic logic [DW-1:0] init_val(input int i);
    return (i == 16) ? 16'hBEEF : (16'(i * 257) ^ 16'h5A5A);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_ready <= 1'b1;
      sram_rdata <= '0;
      busy_left  <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (start && !stuck) begin
      sram_ready <= 1'b0;
      busy_left  <= (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 4));
      op_rw      <= select ? rw_b : rw_a;
      op_addr    <= select ? addr_b[7:0] : addr_a[7:0];
      op_wd      <= select ? wdata_b : wdata_a;
    end else if (busy_left > 1) begin
      busy_left <= busy_left - 1;
    end else if (busy_left == 1) begin
      busy_left  <= 0;
      sram_ready <= 1'b1;
      if (op_rw) sram_rdata <= mem[op_addr];
      else begin
        mem[op_addr] <= op_wd;
        sram_rdata   <= ~op_wd;
      end
    end
  end

  // ---------------- event counters -----------------------------------------
  int   start_cnt = 0, acka_cnt = 0, ackb_cnt = 0;
  logic sel_at_start = 1'b0;
  always @(posedge clk) begin
    if (start) begin
      start_cnt    <= start_cnt + 1;
      sel_at_start <= select;
    end
    if (ack_a) acka_cnt <= acka_cnt + 1;
    if (ack_b) ackb_cnt <= ackb_cnt + 1;
  end

  // ---------------- reference model ----------------------------------------
  logic [DW-1:0] ref_mem [0:255];
  logic [DW-1:0] exp_rdata;
  int            starve;
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ref_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    exp_rdata = '0;
    starve    = 0;
  endtask

  // Priority rule: A wins unless B has waited through MAXW A-grants.
  task automatic grant(input bit pa, input bit pb, output int w);
    if (pa && pb) w = (starve == MAXW) ? 1 : 0;
    else          w = pa ? 0 : 1;
    if (w == 1)       starve = 0;
    else if (pb)      starve = (starve < MAXW) ? starve + 1 : starve;
  endtask

  task automatic complete(input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input bit abort, input string tag);
    if (!abort) begin
      if (rw) exp_rdata = ref_mem[a[7:0]];
      else    ref_mem[a[7:0]] = d;
    end
    chk({tag, "_rdata"}, 32'(rdata), 32'(exp_rdata));
  endtask

  task automatic wait_ack(input int bound, output int port, output int n);
    port = -1;
    n    = 0;
    while (port < 0 && n < bound) begin
      @(negedge clk);
      n++;
      if (ack_a && ack_b) port = 2;
      else if (ack_a)     port = 0;
      else if (ack_b)     port = 1;
    end
    if (port < 0) chk("ack_within_bound", 32'd0, 32'd1);
  endtask

  task automatic new_op(input int p);
    if (p == 0) begin
      rw_a = 1'($urandom % 2); addr_a = AW'($urandom); wdata_a = DW'($urandom);
    end else begin
      rw_b = 1'($urandom % 2); addr_b = AW'($urandom); wdata_b = DW'($urandom);
    end
  endtask

  task automatic single(input int port, input bit rw, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit abort, input int bound,
                        input string tag, output int n);
    int p, w;
    if (port == 0) begin req_a = 1'b1; rw_a = rw; addr_a = a; wdata_a = d; end
    else           begin req_b = 1'b1; rw_b = rw; addr_b = a; wdata_b = d; end
    grant(port == 0, port == 1, w);
    wait_ack(bound, p, n);
    chk({tag, "_port"}, 32'(p), 32'(w));
    complete(rw, a, d, abort, tag);
    req_a = 1'b0;
    req_b = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  p, n, w, s0, a0, b0;
    bit  pa, pb;
    ref_reset();

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_select", 32'(select), 0);
    chk("rst_start",  32'(start),  0);
    chk("rst_acks",   32'({ack_a, ack_b}), 0);
    chk("rst_rdata",  32'(rdata),  0);
    chk("rst_err",    32'(err),    0);
    rst = 1'b0;
    @(negedge clk);

    // 1: A read, minimum latency
    lat_fix = 1;
    s0 = start_cnt; b0 = ackb_cnt;
    single(0, 1'b1, 16'h0010, 16'h0000, 1'b0, 20, "t1", n);
    chk("t1_latency", 32'(n), 32'd4);
    chk("t1_beef", 32'(rdata), 32'hBEEF);
    chk("t1_sel", 32'(sel_at_start), 0);
    chk("t1_starts", 32'(start_cnt - s0), 1);
    chk("t1_no_ackb", 32'(ackb_cnt - b0), 0);

    // 2: B write
    s0 = start_cnt; b0 = ackb_cnt;
    single(1, 1'b0, 16'h00FF, 16'h1234, 1'b0, 20, "t2", n);
    chk("t2_sel", 32'(sel_at_start), 1);
    chk("t2_rdata_held", 32'(rdata), 32'hBEEF);
    chk("t2_mem", 32'(mem[255]), 32'h1234);
    chk("t2_ackb_once", 32'(ackb_cnt - b0), 1);
    chk("t2_starts", 32'(start_cnt - s0), 1);

    // 3: both held continuously, random ops and latency
    lat_fix = 0;
    new_op(0); new_op(1);
    req_a = 1'b1; req_b = 1'b1;
    for (int g = 0; g < 15; g++) begin
      grant(1'b1, 1'b1, w);
      wait_ack(40, p, n);
      chk($sformatf("t3_grant%0d", g), 32'(p), 32'(w));
      if (p == 0)      begin complete(rw_a, addr_a, wdata_a, 1'b0, "t3"); new_op(0); end
      else if (p == 1) begin complete(rw_b, addr_b, wdata_b, 1'b0, "t3"); new_op(1); end
    end
    req_a = 1'b0; req_b = 1'b0;

    // random mix of single/dual requests with random drop-out after ack
    pa = 1'b0; pb = 1'b0;
    for (int g = 0; g < 30; g++) begin
      if (!pa && !pb) begin
        @(negedge clk);
        pa = 1'($urandom % 2);
        pb = 1'($urandom % 2);
        if (!pa && !pb) pa = 1'b1;
        if (pa) new_op(0);
        if (pb) new_op(1);
        req_a = pa; req_b = pb;
      end
      grant(pa, pb, w);
      wait_ack(40, p, n);
      chk($sformatf("rnd_grant%0d", g), 32'(p), 32'(w));
      if (p == 0) begin
        complete(rw_a, addr_a, wdata_a, 1'b0, "rnd");
        pa = 1'($urandom % 2);
        if (pa) new_op(0);
        req_a = pa;
      end else if (p == 1) begin
        complete(rw_b, addr_b, wdata_b, 1'b0, "rnd");
        pb = 1'($urandom % 2);
        if (pb) new_op(1);
        req_b = pb;
      end else begin
        pa = 1'b0; pb = 1'b0; req_a = 1'b0; req_b = 1'b0;
      end
    end
    req_a = 1'b0; req_b = 1'b0;
    @(negedge clk);

    // 4: controller never goes busy -> timeout abort, then normal access
    stuck = 1'b1;
    single(0, 1'b1, 16'h0042, 16'h0000, 1'b1, 300, "t4", n);
    chk("t4_window", 32'(n >= 256 && n <= 258), 1);
    chk("t4_err", 32'(err), 1);
    stuck = 1'b0;
    single(0, 1'b1, 16'h0010, 16'h0000, 1'b0, 40, "t4b", n);
    chk("t4b_err_sticky", 32'(err), 1);

    // 5: reset during WAIT_DONE
    lat_fix = 6;
    req_b = 1'b1; rw_b = 1'b1; addr_b = 16'h0033;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_select", 32'(select), 0);
    chk("t5_start",  32'(start),  0);
    chk("t5_acks",   32'({ack_a, ack_b}), 0);
    chk("t5_rdata",  32'(rdata),  0);
    chk("t5_err",    32'(err),    0);
    req_b = 1'b0;
    a0 = acka_cnt; b0 = ackb_cnt;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    ref_reset();
    lat_fix = 0;
    chk("t5_no_ack", 32'((acka_cnt - a0) + (ackb_cnt - b0)), 0);
    single(0, 1'b1, 16'h0010, 16'h0000, 1'b0, 40, "t5_after", n);

    // 6: B drops req in WAIT_BUSY; access still completes
    lat_fix = 3;
    s0 = start_cnt; b0 = ackb_cnt;
    req_b = 1'b1; rw_b = 1'b0; addr_b = 16'h0077; wdata_b = 16'h7777;
    grant(1'b0, 1'b1, w);
    repeat (2) @(negedge clk);
    req_b = 1'b0;
    wait_ack(20, p, n);
    chk("t6_port", 32'(p), 32'(w));
    complete(1'b0, 16'h0077, 16'h7777, 1'b0, "t6");
    repeat (6) @(negedge clk);
    chk("t6_ackb_once", 32'(ackb_cnt - b0), 1);
    chk("t6_starts", 32'(start_cnt - s0), 1);
    chk("t6_select_held", 32'(select), 1);
    chk("t6_mem", 32'(mem[8'h77]), 32'h7777);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
